// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operation encodings, FSM state encoding and small helpers.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// Execute-stage <-> multiply/divide controller bundle: request side
// (start/op/operands/cancel) and the HI/LO write-back side.
interface hilo_md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        ready;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        done;

  modport master (
    output start, op, src1, src2, cancel,
    input  ready, busy, hi_we, lo_we, hi_wdata, lo_wdata, done
  );

  modport slave (
    input  start, op, src1, src2, cancel,
    output ready, busy, hi_we, lo_we, hi_wdata, lo_wdata, done
  );
endinterface

// File: rtl/md_div_core.sv
// Iterative unsigned restoring divider: load latches the operands,
// each step retires one quotient bit (MSB first).
module md_div_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [32:0] partial;
  logic [32:0] diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    partial = {rem, quo[31]};
    diff    = partial - {1'b0, dvs};
  end

  // Working registers: load, shift-subtract step, or flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (clear) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= partial[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer and sole HI/LO write arbiter.
// Optional feature macro: MD_EARLY_OUT_EN -- divisions whose divisor
// magnitude exceeds the dividend magnitude finish in one edge.
module hilo_md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_ITER = 32
) (
  input logic           clk,
  input logic           resetn,
  hilo_md_ctrl_if.slave md
);
  localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITER);

  md_state_e   state;
  md_state_e   state_nxt;
  logic [5:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        q_neg;
  logic        r_neg;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        div_signed;
  logic        div_zero;
  logic        early_out;
  logic        div_load;
  logic        div_step;
  logic [31:0] src1_mag;
  logic [31:0] src2_mag;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  // Full 64-bit product; sign-extending to 64 bits makes the truncated
  // product exact for both signed and unsigned operands.
  function automatic logic [63:0] mul_product(input logic sgn, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
    eb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    return $unsigned(ea * eb);
  endfunction

  // Restore the sign of an unsigned divider result.
  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] v);
    logic signed [31:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  assign accept     = md.start & (state == S_IDLE) & ~md.cancel;
  assign is_mul     = (md.op == MD_MULT) | (md.op == MD_MULTU);
  assign is_div     = (md.op == MD_DIV) | (md.op == MD_DIVU);
  assign div_signed = (md.op == MD_DIV);
  assign div_zero   = (md.src2 == 32'd0);
  assign src1_mag   = mag32(div_signed, md.src1);
  assign src2_mag   = mag32(div_signed, md.src2);

`ifdef MD_EARLY_OUT_EN
  assign early_out = (src2_mag > src1_mag);
`else
  assign early_out = 1'b0;
`endif

  assign div_load = accept & is_div & ~div_zero & ~early_out;
  assign div_step = (state == S_DIV) & (cnt != DIV_LAST) & ~md.cancel;

  md_div_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (md.cancel),
    .load      (div_load),
    .step      (div_step),
    .dividend  (src1_mag),
    .divisor   (src2_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and HI/LO write decode; MTHI/MTLO bypass the FSM.
  always_comb begin
    state_nxt   = state;
    md.ready    = 1'b0;
    md.busy     = 1'b1;
    md.hi_we    = 1'b0;
    md.lo_we    = 1'b0;
    md.done     = 1'b0;
    md.hi_wdata = '0;
    md.lo_wdata = '0;
    case (state)
      S_IDLE: begin
        md.ready = 1'b1;
        md.busy  = 1'b0;
        if (accept) begin
          if (is_mul)      state_nxt = S_MUL;
          else if (is_div) state_nxt = (div_zero | early_out) ? S_DONE : S_DIV;
          if (md.op == MD_MTHI) begin
            md.hi_we    = 1'b1;
            md.hi_wdata = md.src1;
          end
          if (md.op == MD_MTLO) begin
            md.lo_we    = 1'b1;
            md.lo_wdata = md.src1;
          end
        end
      end
      S_MUL:   if (cnt == 6'd0) state_nxt = S_DONE;
      S_DIV:   if (cnt == DIV_LAST) state_nxt = S_DONE;
      S_DONE: begin
        md.hi_we    = 1'b1;
        md.lo_we    = 1'b1;
        md.done     = 1'b1;
        md.hi_wdata = res_hi;
        md.lo_wdata = res_lo;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (md.cancel) begin
      state_nxt   = S_IDLE;
      md.hi_we    = 1'b0;
      md.lo_we    = 1'b0;
      md.done     = 1'b0;
      md.hi_wdata = '0;
      md.lo_wdata = '0;
    end
  end

  // Counter and result registers; the final DIV cycle applies sign fix-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (md.cancel) begin
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (accept && is_mul) begin
      {res_hi, res_lo} <= mul_product(md.op == MD_MULT, md.src1, md.src2);
      cnt              <= MUL_INIT;
    end else if (accept && is_div) begin
      q_neg <= div_signed & (md.src1[31] ^ md.src2[31]);
      r_neg <= div_signed & md.src1[31];
      cnt   <= '0;
      if (div_zero) begin
        res_hi <= md.src1;
        res_lo <= DIVZERO_LO;
      end else if (early_out) begin
        res_hi <= md.src1;
        res_lo <= '0;
      end
    end else if (state == S_MUL && cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end else if (state == S_DIV) begin
      if (cnt != DIV_LAST) begin
        cnt <= cnt + 6'd1;
      end else begin
        res_lo <= apply_sign(q_neg, div_quo);
        res_hi <= apply_sign(r_neg, div_rem);
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: the driver predicts every HI/LO
// write (cycle, strobes, data) and the per-cycle busy level from a
// behavioural model; a negedge monitor compares against the DUT.
module tb_hilo_md_ctrl;
  import md_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_EXTRA = 33;
  localparam int MAXC = 4096;

  typedef struct {
    int          cyc;
    logic        hwe;
    logic        lwe;
    logic        dn;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  hilo_md_ctrl_if md();

  hilo_md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (md)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  bit   busy_exp[MAXC];
  int   idle_cyc = 0;
  int   last_done = 0;
  int   checks = 0;
  int   errors = 0;
  bit   finish_req = 1'b0;

  // Reference results from plain arithmetic; extra = edges from accept edge to DONE.
  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output int extra);
    logic [63:0] p;
    int q, r;
    longint ma, mb;
    hi = 0; lo = 0; extra = 0;
    if (op == MD_MULT || op == MD_MULTU) begin
      if (op == MD_MULT) p = longint'($signed(a)) * longint'($signed(b));
      else               p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0]; extra = MUL_LAT;
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; extra = 0;
    end else begin
      if (op == MD_DIV) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          lo = q; hi = r;
        end
        ma = longint'($signed(a)); mb = longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
      end else begin
        lo = a / b; hi = a % b;
        ma = longint'(a); mb = longint'(b);
      end
      extra = DIV_EXTRA;
`ifdef MD_EARLY_OUT_EN
      if (mb > ma) extra = 0;
`else
      if (mb > ma) extra = DIV_EXTRA;
`endif
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called 1 time unit after a rising edge; holds start until the model's accept cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it);
    int ca;
    int extra;
    exp_t e;
    logic [31:0] hi, lo;
    ca = (cyc > idle_cyc) ? cyc : idle_cyc;
    md.start = 1'b1; md.op = op; md.src1 = a; md.src2 = b;
    if (op == MD_MTHI || op == MD_MTLO) begin
      e = '{ca, (op == MD_MTHI), (op == MD_MTLO), 1'b0, a, a};
      if (expect_it) sbq.push_back(e);
      idle_cyc = ca + 1;
    end else if (op <= MD_DIVU) begin
      ref_result(op, a, b, hi, lo, extra);
      last_done = ca + 1 + extra;
      e = '{last_done, 1'b1, 1'b1, 1'b1, hi, lo};
      if (expect_it) sbq.push_back(e);
      for (int c = ca + 1; c <= last_done && c < MAXC; c++) busy_exp[c] = 1'b1;
      idle_cyc = last_done + 1;
    end else begin
      ca = cyc;
    end
    while (cyc < ca) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    md.start = 1'b0; md.op = 3'd0; md.src1 = 32'd0; md.src2 = 32'd0;
  endtask

  task automatic cancel_pulse();
    md.cancel = 1'b1;
    for (int c = cyc + 1; c < MAXC; c++) busy_exp[c] = 1'b0;
    idle_cyc = cyc + 1;
    @(posedge clk); #1;
    md.cancel = 1'b0;
  endtask

  // Monitor: busy/ready level every cycle, reset outputs, and scoreboard pops on writes.
  always @(negedge clk) begin
    exp_t e;
    if (finish_req) begin
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL pending_writes: %0d outstanding, required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else begin
      if (cyc < MAXC) begin
        checks++;
        if (md.busy !== busy_exp[cyc] || md.ready !== !busy_exp[cyc]) begin
          errors++;
          $display("FAIL busy_ready cyc=%0d: busy=%b ready=%b, required busy=%b ready=%b",
                   cyc, md.busy, md.ready, busy_exp[cyc], !busy_exp[cyc]);
        end
      end
      if (!resetn) begin
        checks++;
        if (md.hi_we !== 1'b0 || md.lo_we !== 1'b0 || md.done !== 1'b0 ||
            md.hi_wdata !== 32'd0 || md.lo_wdata !== 32'd0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d: hi_we=%b lo_we=%b done=%b hi=%h lo=%h, required all 0",
                   cyc, md.hi_we, md.lo_we, md.done, md.hi_wdata, md.lo_wdata);
        end
      end
      if (md.hi_we === 1'b1 || md.lo_we === 1'b1 || md.done === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d: hi_we=%b lo_we=%b done=%b hi=%h lo=%h, required no write",
                   cyc, md.hi_we, md.lo_we, md.done, md.hi_wdata, md.lo_wdata);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.cyc || md.hi_we !== e.hwe || md.lo_we !== e.lwe || md.done !== e.dn ||
              (e.hwe && md.hi_wdata !== e.hi) || (e.lwe && md.lo_wdata !== e.lo)) begin
            errors++;
            $display("FAIL write cyc=%0d hi_we=%b lo_we=%b done=%b hi=%h lo=%h, required cyc=%0d hi_we=%b lo_we=%b done=%b hi=%h lo=%h",
                     cyc, md.hi_we, md.lo_we, md.done, md.hi_wdata, md.lo_wdata,
                     e.cyc, e.hwe, e.lwe, e.dn, e.hi, e.lo);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          r;
    resetn = 1'b0;
    md.start = 1'b0; md.op = 3'd0; md.src1 = 32'd0; md.src2 = 32'd0; md.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle_cyc = cyc;

    issue(MD_MTHI,  32'h1234_5678, 32'd0, 1'b1);
    issue(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(MD_DIVU,  32'd100,       32'd7, 1'b1);
    issue(MD_DIVU,  32'd5,         32'd0, 1'b1);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(MD_DIVU,  32'd3,         32'd9, 1'b1);

    // Cancel a division at iteration 10, then a MULT right after.
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_cycles(10);
    cancel_pulse();
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFB, 1'b1);

    // MTLO requested while a division is in flight.
    issue(MD_DIVU, 32'd1000, 32'd3, 1'b1);
    issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b1);

    // Cancel landing on the DONE cycle suppresses the write.
    issue(MD_MULT, 32'd9, 32'd9, 1'b0);
    while (cyc < last_done) begin @(posedge clk); #1; end
    cancel_pulse();

    // Cancel together with MTHI in IDLE: no write.
    md.start = 1'b1; md.op = MD_MTHI; md.src1 = 32'hDEAD_BEEF; md.cancel = 1'b1;
    @(posedge clk); #1;
    md.start = 1'b0; md.op = 3'd0; md.src1 = 32'd0; md.cancel = 1'b0;

    issue(3'd6, 32'd1, 32'd2, 1'b1);
    issue(3'd7, 32'd3, 32'd4, 1'b1);

    // Reset in the middle of a division.
    issue(MD_DIVU, 32'd50, 32'd5, 1'b0);
    wait_cycles(3);
    #1 resetn = 1'b0;
    for (int c = cyc; c < MAXC; c++) busy_exp[c] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle_cyc = cyc;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 7);
      if (r == 0) b = 32'd0;
      if (r == 1) b = $urandom_range(1, 15);
      if (r == 2) a = $urandom_range(0, 100);
      if (r == 3) b = 32'hFFFF_FFFF;
      issue(op, a, b, 1'b1);
      wait_cycles($urandom_range(0, 2));
    end

    while (cyc < idle_cyc + 2) begin @(posedge clk); #1; end
    finish_req = 1'b1;
  end

endmodule
